line_merge_unit: RTL and testbench
==================================

// Module: line_merge_unit
//
// PURPOSE
// - Parametrised successor to the per-cell 2048 node: slides and merges one whole line of N tiles in one transaction.
// - Tiles are W-bit exponents; 0 means empty. Cell 0 is the merge target unless reverse=1.
// - Sits between the board register file and the move controller. The controller issues one start per row or column.
// - Returns the new line, a moved flag, the merge count and (optionally) the score delta.
//
// PARAMETERS
// - N        4   cells per line (>=2)
// - W        4   bits per tile exponent; exponent 2^W-1 is the maximum tile and never merges
// - SCORE_W  16  score-delta width; the delta saturates at 2^SCORE_W-1
//
// PORTS
// - clk        in   1       single clock, rising edge
// - rst        in   1       reset, asynchronous, active-high
// - start      in   1       request; accepted only when busy=0
// - reverse    in   1       0: merge toward cell 0; 1: merge toward cell N-1 (sampled with start)
// - line_in    in   N*W     cell i = line_in[i*W +: W] (sampled with start)
// - busy       out  1       high from the cycle after acceptance through the done cycle
// - done       out  1       one-cycle pulse; results are valid from this cycle on
// - line_out   out  N*W     merged line; held until the next acceptance
// - moved      out  1       line_out != line_in as sampled
// - merge_cnt  out  $clog2(N/2+1)  number of merges performed
// - score      out  SCORE_W only with LINE_MERGE_SCORE_EN: sum of 2^(e+1) over the merges
//
// BEHAVIOUR
// - Reset (async): FSM=IDLE; busy, done, moved, merge_cnt, score and line_out are all 0.
// - FSM states: IDLE -> SCAN -> FLUSH -> DONE -> IDLE.
// - IDLE: start=1 latches line_in and reverse. If reverse=1 the cells are reordered so that cell N-1 is processed first.
// - SCAN: runs for N cycles, one cell per cycle, using read index rd (0..N-1). It also keeps write index wr, a hold register h and a flag hv.
//   - Cell c==0: skip.
//   - hv=1, h==c, c!=2^W-1: write h+1 at wr, wr++, clear hv, merge_cnt++, score += 1<<(c+1).
//   - hv=1, otherwise: write h at wr, wr++, set h=c.
//   - hv=0: set h=c, hv=1.
// - FLUSH: one cycle. If hv=1, write h at wr. Cells from wr+1 to N-1 are 0.
// - DONE: one cycle. Un-reverse the cell order, assert done, update line_out and moved, return to IDLE.
// - Latency: if accepted at cycle T, done is high at T+N+2 (T+6 for N=4).
// - A fully merged tile is never merged again in the same pass: [1,1,2] gives [2,2,0], not [3,0,0].
// - start while busy=1 is ignored and has no side effect. start in the DONE cycle is also ignored.
// - Back-to-back operation: start in the cycle after done is accepted.
// - rst mid-operation aborts immediately. No done is produced, and outputs take their reset values.
// - Width rules:
//   - Merged exponent h+1 cannot overflow, because the maximum tile never merges.
//   - merge_cnt <= N/2.
//   - score uses saturating add.
//
// CONFIGURATION
// - LINE_MERGE_SCORE_EN defined: the score port and accumulator exist. score is cleared at acceptance and valid at done.
// - LINE_MERGE_SCORE_EN undefined: no score port and no accumulator. All other behaviour and timing are identical.
//
// STRUCTURE
// - Package game_pkg holds:
//   - FSM state typedef (IDLE/SCAN/FLUSH/DONE);
//   - EMPTY_TILE = '0;
//   - helper function max_tile(W) = 2^W-1.
// - Sub-module line_order_swap: combinational cell-order reversal with pass-through when reverse=0.
//   - Instantiated twice: on the input side and on the output side.
// - Everything else (FSM, pointers, hold register, accumulators) stays in line_merge_unit.
//
// TESTING (N=4, W=4; lines written as [c0,c1,c2,c3])
// 1. [1,1,1,1], rev=0 -> [2,2,0,0]; merge_cnt=2; moved=1; score=8; done at T+6.
// 2. [0,2,0,2], rev=0 -> [3,0,0,0]; merge_cnt=1; moved=1; score=8.
// 3. [1,2,3,4], rev=0 -> unchanged; moved=0; merge_cnt=0; score=0.
// 4. [15,15,0,0] -> unchanged (maximum tile does not merge); moved=0.
// 5. [2,2,2,0], rev=1 -> [0,0,2,3]; merge_cnt=1; score=8.
// 6. Second start at T+2 ignored; rst at T+3 -> busy=0, line_out=0, no done pulse; a new start is then accepted normally.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared FSM state, empty-tile constant and tile helpers for line_merge_unit
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } state_t;

    localparam logic [31:0] EMPTY_TILE = '0;

    function automatic int max_tile(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/line_order_swap.sv
// rtl/line_order_swap.sv - combinational cell-order reversal, pass-through when reverse=0
module line_order_swap #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic           reverse,
    input  logic [N*W-1:0] line_in,
    output logic [N*W-1:0] line_out
);

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign line_out[i*W +: W] = reverse ? line_in[(N-1-i)*W +: W] : line_in[i*W +: W];
    end

endmodule

// File: rtl/line_merge_unit.sv
// rtl/line_merge_unit.sv - slides and merges one line of N tiles per transaction
// Optional score port and accumulator: LINE_MERGE_SCORE_EN
module line_merge_unit
    import game_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int SCORE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       reverse,
    input  logic [N*W-1:0]             line_in,
    output logic                       busy,
    output logic                       done,
    output logic [N*W-1:0]             line_out,
    output logic                       moved,
    output logic [$clog2(N/2+1)-1:0]   merge_cnt
`ifdef LINE_MERGE_SCORE_EN
    ,
    output logic [SCORE_W-1:0]         score
`endif
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam int MW = $clog2(N/2+1);
    localparam logic [W-1:0] MAX_T = W'(max_tile(W));
    localparam logic [W-1:0] EMPTY = EMPTY_TILE[W-1:0];

    state_t         state;
    logic [N*W-1:0] work;
    logic [N*W-1:0] obuf;
    logic [N*W-1:0] fin;
    logic [N*W-1:0] in_sw;
    logic [N*W-1:0] fin_sw;
    logic [IW-1:0]  rd;
    logic [IW-1:0]  wr;
    logic [W-1:0]   h;
    logic [W-1:0]   c;
    logic           hv;
    logic           rev_q;

    line_order_swap #(.N(N), .W(W)) u_in_swap (
        .reverse  (reverse),
        .line_in  (line_in),
        .line_out (in_sw)
    );

    line_order_swap #(.N(N), .W(W)) u_out_swap (
        .reverse  (rev_q),
        .line_in  (fin),
        .line_out (fin_sw)
    );

    // fin is the scan buffer with any pending hold tile flushed in.
    always_comb begin
        c   = work[int'(rd)*W +: W];
        fin = obuf;
        if (hv) begin
            fin[int'(wr)*W +: W] = h;
        end
    end

`ifdef LINE_MERGE_SCORE_EN
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [W-1:0] e);
        logic [SCORE_W:0] s;
        if (int'(e) + 1 >= SCORE_W) begin
            return '1;
        end
        s = {1'b0, a} + ((SCORE_W+1)'(1) << (int'(e) + 1));
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            line_out  <= '0;
            moved     <= 1'b0;
            merge_cnt <= '0;
            work      <= '0;
            obuf      <= '0;
            rd        <= '0;
            wr        <= '0;
            h         <= '0;
            hv        <= 1'b0;
            rev_q     <= 1'b0;
`ifdef LINE_MERGE_SCORE_EN
            score     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work      <= in_sw;
                        rev_q     <= reverse;
                        obuf      <= '0;
                        rd        <= '0;
                        wr        <= '0;
                        h         <= '0;
                        hv        <= 1'b0;
                        merge_cnt <= '0;
`ifdef LINE_MERGE_SCORE_EN
                        score     <= '0;
`endif
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (c != EMPTY) begin
                        if (hv) begin
                            // Merging clears hv, so a merged tile cannot merge again this pass.
                            if (h == c && c != MAX_T) begin
                                obuf[int'(wr)*W +: W] <= h + W'(1);
                                wr        <= wr + IW'(1);
                                hv        <= 1'b0;
                                merge_cnt <= merge_cnt + MW'(1);
`ifdef LINE_MERGE_SCORE_EN
                                score     <= sat_add(score, c);
`endif
                            end else begin
                                obuf[int'(wr)*W +: W] <= h;
                                wr <= wr + IW'(1);
                                h  <= c;
                            end
                        end else begin
                            h  <= c;
                            hv <= 1'b1;
                        end
                    end
                    rd <= rd + IW'(1);
                    if (rd == IW'(N-1)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    line_out <= fin_sw;
                    moved    <= (fin != work);
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_merge_unit.sv
// tb/tb_line_merge_unit.sv - scoreboard bench for line_merge_unit (N=4, W=4), score checked with LINE_MERGE_SCORE_EN
module tb_line_merge_unit;

    localparam int N = 4;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        reverse;
    logic [15:0] line_in;
    logic        busy;
    logic        done;
    logic [15:0] line_out;
    logic        moved;
    logic [1:0]  merge_cnt;
`ifdef LINE_MERGE_SCORE_EN
    logic [15:0] score;
`endif

    line_merge_unit #(.N(N), .W(W), .SCORE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reverse   (reverse),
        .line_in   (line_in),
        .busy      (busy),
        .done      (done),
        .line_out  (line_out),
        .moved     (moved),
        .merge_cnt (merge_cnt)
`ifdef LINE_MERGE_SCORE_EN
        ,
        .score     (score)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] line;
        bit          moved;
        int          mc;
        int          sc;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [15:0] mk(input int a, input int b, input int c, input int d);
        return {d[3:0], c[3:0], b[3:0], a[3:0]};
    endfunction

    function automatic exp_t mkexp(input logic [15:0] l, input bit m, input int mc, input int sc);
        exp_t e;
        e.line = l; e.moved = m; e.mc = mc; e.sc = sc; e.cyc = 0;
        return e;
    endfunction

    // Reference: collect the non-empty tiles in processing order, then pair equal neighbours left to right.
    function automatic exp_t model(input logic [15:0] lin, input bit rev);
        exp_t e;
        int cells[4];
        int o[4];
        int q[$];
        int i, k;
        logic [15:0] r;
        for (int j = 0; j < 4; j++) begin
            cells[j] = rev ? int'(lin[(3-j)*4 +: 4]) : int'(lin[j*4 +: 4]);
            o[j] = 0;
            if (cells[j] != 0) q.push_back(cells[j]);
        end
        e.mc = 0; e.sc = 0;
        i = 0; k = 0;
        while (i < q.size()) begin
            if (i + 1 < q.size() && q[i] == q[i+1] && q[i] != 15) begin
                o[k] = q[i] + 1;
                e.mc++;
                e.sc += 1 << (q[i] + 1);
                i += 2;
            end else begin
                o[k] = q[i];
                i++;
            end
            k++;
        end
        if (e.sc > 65535) e.sc = 65535;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            if (rev) r[(3-j)*4 +: 4] = 4'(o[j]);
            else     r[j*4 +: 4]     = 4'(o[j]);
        end
        e.line = r;
        e.moved = (r != lin);
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sbq.pop_front();
                    chk("line_out", int'(line_out), int'(e.line));
                    chk("moved", int'(moved), int'(e.moved));
                    chk("merge_cnt", int'(merge_cnt), e.mc);
`ifdef LINE_MERGE_SCORE_EN
                    chk("score", int'(score), e.sc);
`endif
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_at_done", int'(busy), 1);
                end
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (done) break;
            start   = ($urandom % 4 == 0);
            line_in = 16'($urandom);
            reverse = 1'($urandom);
            n++;
        end
        if (n >= 40) begin
            chk("done_timeout", 0, 1);
            sbq.delete();
            start = 1'b0;
        end else begin
            start   = 1'($urandom);
            line_in = 16'($urandom);
        end
    endtask

    task automatic issue(input logic [15:0] l, input bit rev, input exp_t e, input int gap);
        int n;
        @(negedge clk);
        if (gap > 0) begin
            start = 1'b0;
            repeat (gap) @(negedge clk);
        end
        n = 0;
        while (busy && n < 50) begin
            start = 1'b0;
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_wait", int'(busy), 0);
        start   = 1'b1;
        line_in = l;
        reverse = rev;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.cyc = cyc + N + 1;
        sbq.push_back(e);
        chk("busy_after_accept", int'(busy), 1);
        wait_done();
    endtask

    initial begin
        int seen;
        logic [15:0] l;
        bit rv;
        rst = 1'b1; start = 1'b0; reverse = 1'b0; line_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_line_out", int'(line_out), 0);
        chk("rst_moved", int'(moved), 0);
        chk("rst_merge_cnt", int'(merge_cnt), 0);
`ifdef LINE_MERGE_SCORE_EN
        chk("rst_score", int'(score), 0);
`endif
        rst = 1'b0;

        issue(mk(1,1,1,1), 1'b0, mkexp(mk(2,2,0,0), 1'b1, 2, 8), 0);
        issue(mk(0,2,0,2), 1'b0, mkexp(mk(3,0,0,0), 1'b1, 1, 8), 0);
        issue(mk(1,2,3,4), 1'b0, mkexp(mk(1,2,3,4), 1'b0, 0, 0), 1);
        issue(mk(15,15,0,0), 1'b0, mkexp(mk(15,15,0,0), 1'b0, 0, 0), 0);
        issue(mk(2,2,2,0), 1'b1, mkexp(mk(0,0,2,3), 1'b1, 1, 8), 0);
        issue(mk(1,1,2,0), 1'b0, mkexp(mk(2,2,0,0), 1'b1, 1, 4), 2);

        // Abort: second start at T+2 is ignored, rst at T+3 kills the pass.
        @(negedge clk);
        start = 1'b1; line_in = mk(1,1,1,1); reverse = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; line_in = mk(3,3,0,0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_line_out", int'(line_out), 0);
        chk("abort_merge_cnt", int'(merge_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        issue(mk(1,1,1,1), 1'b0, mkexp(mk(2,2,0,0), 1'b1, 2, 8), 0);

        for (int t = 0; t < 150; t++) begin
            l = '0;
            for (int j = 0; j < 4; j++) begin
                int v;
                v = $urandom_range(0, 9);
                l[j*4 +: 4] = (v < 3) ? 4'd0 : (v == 9) ? 4'd15 : 4'(v - 2);
            end
            rv = 1'($urandom);
            issue(l, rv, model(l, rv), $urandom_range(0, 2));
        end

        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
